mode_stopwatch_lap: RTL and testbench

- Parametrised stopwatch mode for the 16x2 character LCD path, with explicit run/pause/idle control and a circular lap-capture buffer.
- Counts in BCD (centiseconds, seconds, minutes) from an internal tick divider.
- Returns one ASCII character per cycle for the display scanner's 5-bit `index` (0-15 line 1, 16-31 line 2).
- Line 2 shows either live time or a recalled lap.

---
 rtl/mode_stopwatch_lap.sv | 175 +++++++++++++++++
 tb/tb_mode_stopwatch_lap.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mode_stopwatch_lap.sv
// Stopwatch mode for the 16x2 LCD path: BCD mm:ss:cc counter with run/pause/idle
// control and a circular lap buffer, returning one ASCII character per index.
module mode_stopwatch_lap #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4,
    parameter int MAX_MIN   = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    input  logic [4:0] index,
    output logic [7:0] out,
    output logic       running,
    output logic [3:0] lap_count,
    output logic       ovf
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAP_DEPTH - 1);
    localparam logic [7:0] MAX_M = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));
    localparam logic [3:0] DEPTH = 4'(LAP_DEPTH);
    localparam logic [7:0] TITLE [10] = '{"S", "t", "o", "p", " ", "W", "a", "t", "c", "h"};
    localparam logic [7:0] LBL_LIVE [4] = '{"T", "I", "M", "E"};
    localparam logic [7:0] LBL_LAP [4] = '{"L", "A", "P", " "};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       sw_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [23:0]      time_q, time_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]       view_q, view_d;
    logic [7:0]       out_q, out_d;
    logic [23:0]      lap_buf_q [LAP_DEPTH];

    logic [3:0]       sw_edge;
    logic             tick, cs_wrap, s_wrap, m_wrap, clr_acc, lap_we;
    logic [7:0]       cs_n, s_n, m_n;
    logic [4:0]       rd_sum;
    logic [PTR_W-1:0] rd_idx;
    logic [23:0]      disp_time;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        sw_edge = sw_in & ~sw_prev_q;
        tick    = (state_q == S_RUN) && (div_q == DIV_LAST);
        cs_wrap = (time_q[7:0] == 8'h99);
        s_wrap  = (time_q[15:8] == 8'h59);
        m_wrap  = (time_q[23:16] == MAX_M);
        cs_n    = cs_wrap ? 8'h00 : bcd_inc(time_q[7:0]);
        s_n     = cs_wrap ? (s_wrap ? 8'h00 : bcd_inc(time_q[15:8])) : time_q[15:8];
        m_n     = (cs_wrap && s_wrap) ? (m_wrap ? 8'h00 : bcd_inc(time_q[23:16])) : time_q[23:16];
        clr_acc = sw_edge[0] && (state_q != S_RUN);
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        time_d   = time_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        view_d   = view_q;
        lap_we   = 1'b0;
        if (clr_acc) begin
            state_d  = S_IDLE;
            div_d    = '0;
            time_d   = '0;
            ovf_d    = 1'b0;
            cnt_d    = '0;
            wr_ptr_d = '0;
            view_d   = '0;
        end else begin
            case (state_q)
                S_RUN:   div_d = tick ? '0 : div_q + DIV_W'(1);
                S_PAUSE: div_d = div_q;
                default: div_d = '0;
            endcase
            if (tick) begin
                time_d = {m_n, s_n, cs_n};
                if (cs_wrap && s_wrap && m_wrap) ovf_d = 1'b1;
            end
            // Lap stores the pre-tick time_q; a full buffer overwrites the oldest slot.
            if (sw_edge[2] && (state_q == S_RUN)) begin
                lap_we   = 1'b1;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
                if (cnt_q < DEPTH) cnt_d = cnt_q + 4'd1;
            end
            if (sw_edge[1]) begin
                if (state_q == S_RUN) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_RUN;
                    view_d  = '0;
                end
            end else if (sw_edge[3] && (state_q != S_RUN) && (cnt_q != 4'd0)) begin
                view_d = (view_q == cnt_q) ? 4'd0 : view_q + 4'd1;
            end
        end
    end

    // View k maps to the k-th oldest entry; the oldest sits at wr_ptr once the buffer is full.
    always_comb begin
        rd_sum = ((cnt_q < DEPTH) ? 5'd0 : 5'(wr_ptr_q)) + 5'(view_q) - 5'd1;
        if (rd_sum >= 5'(LAP_DEPTH)) rd_sum = rd_sum - 5'(LAP_DEPTH);
        rd_idx    = (view_q == 4'd0) ? '0 : PTR_W'(rd_sum);
        disp_time = (view_q == 4'd0) ? time_q : lap_buf_q[rd_idx];
    end

    always_comb begin
        out_d = 8'h20;
        case (index)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
            5'd5, 5'd6, 5'd7, 5'd8, 5'd9: out_d = TITLE[index[3:0]];
            5'd11: out_d = (view_q != 4'd0) ? 8'h4C : 8'h20;
            5'd12: out_d = (view_q != 4'd0) ? 8'h30 + {4'h0, view_q} : 8'h20;
            5'd14: out_d = (state_q == S_RUN) ? 8'h52 : ((state_q == S_PAUSE) ? 8'h50 : 8'h20);
            5'd15: out_d = ovf_q ? 8'h2A : 8'h20;
            5'd16, 5'd17, 5'd18, 5'd19:
                out_d = (view_q == 4'd0) ? LBL_LIVE[index[1:0]] : LBL_LAP[index[1:0]];
            5'd21: out_d = 8'h30 + {4'h0, disp_time[23:20]};
            5'd22: out_d = 8'h30 + {4'h0, disp_time[19:16]};
            5'd23: out_d = 8'h3A;
            5'd24: out_d = 8'h30 + {4'h0, disp_time[15:12]};
            5'd25: out_d = 8'h30 + {4'h0, disp_time[11:8]};
            5'd26: out_d = 8'h3A;
            5'd27: out_d = 8'h30 + {4'h0, disp_time[7:4]};
            5'd28: out_d = 8'h30 + {4'h0, disp_time[3:0]};
            default: out_d = 8'h20;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sw_prev_q <= '0;
            div_q     <= '0;
            time_q    <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            view_q    <= '0;
            out_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            sw_prev_q <= sw_in;
            div_q     <= div_d;
            time_q    <= time_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            view_q    <= view_d;
            out_q     <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && lap_we) lap_buf_q[wr_ptr_q] <= time_q;
    end

    assign out       = out_q;
    assign running   = (state_q == S_RUN);
    assign lap_count = cnt_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_mode_stopwatch_lap.sv
// Bench for mode_stopwatch_lap: instance A (10 clk/tick, 2 laps) and instance B
// (2 clk/tick, MAX_MIN=1) for the wrap case; expectations flow through a queue.
module tb_mode_stopwatch_lap;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_in = 4'd0;
    logic [4:0] index = 5'd0;
    logic [7:0] out_a, out_b;
    logic       run_a, run_b, ovf_a, ovf_b;
    logic [3:0] cnt_a, cnt_b;

    mode_stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(2), .MAX_MIN(59)) u_a (
        .clk(clk), .rst(rst), .sw_in(sw_in), .index(index),
        .out(out_a), .running(run_a), .lap_count(cnt_a), .ovf(ovf_a));

    mode_stopwatch_lap #(.CLK_HZ(200), .TICK_HZ(100), .LAP_DEPTH(4), .MAX_MIN(1)) u_b (
        .clk(clk), .rst(rst), .sw_in(sw_in), .index(index),
        .out(out_b), .running(run_b), .lap_count(cnt_b), .ovf(ovf_b));

    always #5 clk = ~clk;

    // sel: 0..3 = out/running/lap_count/ovf of A, 4..7 = same of B
    logic [7:0] exp_q[$];
    logic [2:0] sel_q[$];
    string      name_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    logic       req = 1'b0;
    logic       pend = 1'b0;
    logic [7:0] m_exp, m_act;
    logic [2:0] m_sel;
    string      m_name;

    always @(posedge clk) pend <= req;

    always @(negedge clk) begin
        if (pend) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor: output sampled with no expectation queued");
            end else begin
                m_exp  = exp_q.pop_front();
                m_sel  = sel_q.pop_front();
                m_name = name_q.pop_front();
                case (m_sel)
                    3'd0: m_act = out_a;
                    3'd1: m_act = {7'd0, run_a};
                    3'd2: m_act = {4'd0, cnt_a};
                    3'd3: m_act = {7'd0, ovf_a};
                    3'd4: m_act = out_b;
                    3'd5: m_act = {7'd0, run_b};
                    3'd6: m_act = {4'd0, cnt_b};
                    default: m_act = {7'd0, ovf_b};
                endcase
                if (m_act !== m_exp) begin
                    n_fail++;
                    $display("FAIL %s: got 8'h%h, expected 8'h%h", m_name, m_act, m_exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input logic [2:0] sel, input logic [7:0] exp, input string name);
        exp_q.push_back(exp);
        sel_q.push_back(sel);
        name_q.push_back(name);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic rd(input logic dut_b, input logic [4:0] idx, input logic [7:0] exp,
                      input string name);
        index = idx;
        chk(dut_b ? 3'd4 : 3'd0, exp, name);
    endtask

    task automatic rd_str(input logic dut_b, input logic [4:0] start, input string s,
                          input string name);
        for (int i = 0; i < s.len(); i++)
            rd(dut_b, start + 5'(i), s[i], $sformatf("%s[%0d]", name, i));
    endtask

    // One-cycle pulse followed by a released cycle so back-to-back presses form edges.
    task automatic press(input logic [3:0] m);
        sw_in = m;
        @(negedge clk);
        sw_in = 4'd0;
        @(negedge clk);
    endtask

    initial begin
        idle(2);
        chk(3'd0, 8'h00, "rst_out_a");
        chk(3'd1, 8'h00, "rst_running_a");
        chk(3'd2, 8'h00, "rst_lap_count_a");
        chk(3'd3, 8'h00, "rst_ovf_a");
        chk(3'd4, 8'h00, "rst_out_b");
        rst = 1'b0;

        // Run 1000 clk = 100 ticks, then pause on a non-tick cycle.
        press(4'b0010);
        idle(499);
        chk(3'd1, 8'h01, "a_running");
        rd(1'b0, 5'd14, "R", "a_idx14_run");
        idle(498);
        press(4'b0010);
        rd_str(1'b0, 5'd21, "00:01:00", "a_time_1s");
        rd(1'b0, 5'd14, "P", "a_idx14_pause");
        chk(3'd1, 8'h00, "a_paused");
        rd_str(1'b0, 5'd0, "Stop Watch", "a_title");
        rd_str(1'b0, 5'd16, "TIME", "a_label_live");
        rd_str(1'b0, 5'd11, "  ", "a_tag_live");

        // Laps at 00:00:50, 00:01:00, 00:01:50 into a 2-deep buffer.
        press(4'b0001);
        press(4'b0010);
        idle(503);
        press(4'b0100);
        idle(498);
        press(4'b0100);
        idle(498);
        press(4'b0100);
        chk(3'd2, 8'h02, "a_lap_count_sat");
        press(4'b0010);
        press(4'b1000);
        rd_str(1'b0, 5'd11, "L1", "a_tag_lap1");
        rd_str(1'b0, 5'd16, "LAP ", "a_label_lap");
        rd_str(1'b0, 5'd21, "00:01:00", "a_lap1_time");
        press(4'b1000);
        rd_str(1'b0, 5'd11, "L2", "a_tag_lap2");
        rd_str(1'b0, 5'd21, "00:01:50", "a_lap2_time");
        press(4'b1000);
        rd_str(1'b0, 5'd11, "  ", "a_tag_back_live");
        rd_str(1'b0, 5'd16, "TIME", "a_label_back_live");
        rd_str(1'b0, 5'd21, "00:01:50", "a_live_time");

        // Held buttons act once.
        press(4'b0001);
        sw_in = 4'b0010;
        idle(50);
        sw_in = 4'd0;
        idle(1);
        chk(3'd1, 8'h01, "a_hold_start_once");
        sw_in = 4'b0100;
        idle(50);
        sw_in = 4'd0;
        idle(1);
        chk(3'd2, 8'h01, "a_hold_lap_once");
        press(4'b0010);
        press(4'b0001);

        // Lap + start/stop together at 00:00:30; divider phase (5) must survive the pause.
        press(4'b0010);
        idle(303);
        press(4'b0110);
        chk(3'd2, 8'h01, "a_same_lap_count");
        chk(3'd1, 8'h00, "a_same_paused");
        idle(100);
        rd_str(1'b0, 5'd21, "00:00:30", "a_same_frozen");
        press(4'b1000);
        rd_str(1'b0, 5'd21, "00:00:30", "a_same_lap1");
        press(4'b0010);
        idle(3);
        press(4'b0010);
        rd_str(1'b0, 5'd16, "TIME", "a_resume_live");
        rd_str(1'b0, 5'd21, "00:00:31", "a_div_held");

        // Reset while running at 00:02:37 with one lap stored.
        press(4'b0001);
        press(4'b0010);
        idle(100);
        press(4'b0100);
        idle(2271);
        index = 5'd0;
        rst = 1'b1;
        chk(3'd0, 8'h00, "a_midrst_out");
        rst = 1'b0;
        chk(3'd1, 8'h00, "a_midrst_running");
        chk(3'd2, 8'h00, "a_midrst_lap_count");
        rd_str(1'b0, 5'd21, "00:00:00", "a_midrst_time");
        rd(1'b0, 5'd14, " ", "a_midrst_idx14");

        // Instance B: run to 01:59:99, one more tick wraps and sets ovf.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        press(4'b0010);
        idle(23997);
        press(4'b0010);
        rd_str(1'b1, 5'd21, "01:59:99", "b_before_wrap");
        chk(3'd7, 8'h00, "b_ovf_before");
        press(4'b0010);
        press(4'b0010);
        rd_str(1'b1, 5'd21, "00:00:00", "b_wrap_time");
        chk(3'd7, 8'h01, "b_ovf_set");
        rd(1'b1, 5'd15, "*", "b_idx15_star");
        rd(1'b1, 5'd14, "P", "b_idx14_pause");
        press(4'b0010);
        press(4'b0001);
        chk(3'd5, 8'h01, "b_clear_in_run_running");
        chk(3'd7, 8'h01, "b_clear_in_run_ovf");
        press(4'b0010);
        rd_str(1'b1, 5'd21, "00:00:03", "b_clear_in_run_time");
        press(4'b0001);
        chk(3'd7, 8'h00, "b_clear_ovf");
        chk(3'd5, 8'h00, "b_clear_running");
        rd_str(1'b1, 5'd21, "00:00:00", "b_clear_time");
        rd(1'b1, 5'd14, " ", "b_idx14_idle");
        rd(1'b1, 5'd15, " ", "b_idx15_clear");

        idle(2);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
